// File: rtl/pipe_buffer_skid.sv
// Inter-stage pipeline buffer with valid/ready handshake, 2-entry skid storage and synchronous flush.
// Define PIPE_BUFFER_PERF_CNT_EN to add saturating stall_cnt / flush_cnt performance counters.
module pipe_buffer_skid #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 3,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        dataIn_ctrl,
    input  logic [NUM_CH*DATA_W-1:0] dataIn_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        dataOut_ctrl,
    output logic [NUM_CH*DATA_W-1:0] dataOut_data
`ifdef PIPE_BUFFER_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
`endif
);
    localparam int DW = NUM_CH * DATA_W;

    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q, s_ctrl_q;
    logic [DW-1:0]     m_data_q, s_data_q;
    logic              m_load_in, m_load_s, s_load;
    logic              acc, drn;

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
    assign in_ready     = !s_valid_q;
    assign acc          = in_valid & in_ready;
    assign drn          = m_valid_q & out_ready;
    assign out_valid    = m_valid_q;
    assign dataOut_data = m_data_q;
    assign dataOut_ctrl = m_valid_q ? m_ctrl_q : '0;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_load_in = 1'b0;
        m_load_s  = 1'b0;
        s_load    = 1'b0;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q) begin
            if (acc) begin
                m_valid_d = 1'b1;
                m_load_in = 1'b1;
            end
        end else if (drn) begin
            if (s_valid_q) begin
                m_load_s  = 1'b1;
                s_valid_d = 1'b0;
            end else if (acc) begin
                m_load_in = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (acc) begin
            s_load    = 1'b1;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl_q <= '0;
            m_data_q <= '0;
            s_ctrl_q <= '0;
            s_data_q <= '0;
        end else begin
            if (m_load_in) begin
                m_ctrl_q <= dataIn_ctrl;
                m_data_q <= dataIn_data;
            end else if (m_load_s) begin
                m_ctrl_q <= s_ctrl_q;
                m_data_q <= s_data_q;
            end
            if (s_load) begin
                s_ctrl_q <= dataIn_ctrl;
                s_data_q <= dataIn_data;
            end
        end
    end

`ifdef PIPE_BUFFER_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (m_valid_q && !out_ready)
                stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flush && (m_valid_q || s_valid_q))
                flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
